// File: rtl/spi_byte_arbiter.sv
// spi_byte_arbiter
//   Shares one SPI display transmitter between two byte-stream requesters.
//   A granted requester keeps the transmitter until it sends a byte flagged
//   last, or until it stays silent for TIMEOUT cycles while holding the lock.
//   Contention between new packets is resolved round-robin.
//   All registers update on the falling edge of i_clk.
//
// Ports
//   i_clk, i_rst            clock (falling-edge active), async active-high reset
//   i_reqN_valid/data/last  requester N byte offer (held until o_reqN_ack)
//   o_reqN_ack              one-cycle pulse: requester N byte captured
//   o_data_rdy, o_data      one-cycle strobe plus byte for the transmitter
//   i_trans_ena             one-cycle strobe: transmitter finished the byte
//   o_grant                 one-hot owner (01 req0, 10 req1, 00 none)
//   o_busy                  high whenever the FSM is not in IDLE
//   o_timeout_err           one-cycle pulse when a silent owner is released
//
// state   | meaning
// IDLE    | no owner; arbitrate new packets
// SEND    | byte just handed to transmitter; strobes drop
// WAIT_TX | waiting for the transmitter to finish the byte
// HOLD    | packet still open; wait for the owner's next byte or timeout

module spi_byte_arbiter #(
  parameter int TIMEOUT = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  input  logic       i_req0_last,
  output logic       o_req0_ack,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  input  logic       i_req1_last,
  output logic       o_req1_ack,
  output logic       o_data_rdy,
  output logic [7:0] o_data,
  input  logic       i_trans_ena,
  output logic [1:0] o_grant,
  output logic       o_busy,
  output logic       o_timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_HOLD
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_data;
  logic        r_last_flag;
  logic        r_last_grant;
  logic [1:0]  r_grant;
  logic [15:0] r_cnt;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_data_rdy;
  logic        r_timeout_err;

  state_t      w_state_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_last_flag_nxt;
  logic        w_last_grant_nxt;
  logic [1:0]  w_grant_nxt;
  logic [15:0] w_cnt_nxt;
  logic        w_ack0_nxt;
  logic        w_ack1_nxt;
  logic        w_data_rdy_nxt;
  logic        w_timeout_err_nxt;
  logic        w_sel_valid;
  logic        w_sel;

  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_data        <= 8'h00;
      r_last_flag   <= 1'b0;
      r_last_grant  <= 1'b1;
      r_grant       <= 2'b00;
      r_cnt         <= 16'd0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_data_rdy    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_data        <= w_data_nxt;
      r_last_flag   <= w_last_flag_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_grant       <= w_grant_nxt;
      r_cnt         <= w_cnt_nxt;
      r_ack0        <= w_ack0_nxt;
      r_ack1        <= w_ack1_nxt;
      r_data_rdy    <= w_data_rdy_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_data_nxt        = r_data;
    w_last_flag_nxt   = r_last_flag;
    w_last_grant_nxt  = r_last_grant;
    w_grant_nxt       = r_grant;
    w_cnt_nxt         = r_cnt;
    w_ack0_nxt        = 1'b0;
    w_ack1_nxt        = 1'b0;
    w_data_rdy_nxt    = 1'b0;
    w_timeout_err_nxt = 1'b0;
    w_sel_valid       = 1'b0;
    w_sel             = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // last_grant names the requester served last, so the other one wins a tie
        if (i_req0_valid && i_req1_valid) begin
          w_sel_valid = 1'b1;
          w_sel       = ~r_last_grant;
        end else if (i_req0_valid) begin
          w_sel_valid = 1'b1;
          w_sel       = 1'b0;
        end else if (i_req1_valid) begin
          w_sel_valid = 1'b1;
          w_sel       = 1'b1;
        end
      end
      ST_SEND: begin
        w_state_nxt = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_trans_ena) begin
          if (r_last_flag) begin
            w_last_grant_nxt = r_grant[1];
            w_grant_nxt      = 2'b00;
            w_state_nxt      = ST_IDLE;
          end else begin
            w_cnt_nxt   = 16'd0;
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // only the owner is looked at; a capture beats a coincident timeout
        w_sel       = r_grant[1];
        w_sel_valid = r_grant[1] ? i_req1_valid : i_req0_valid;
        if (!w_sel_valid) begin
          if (r_cnt == HOLD_LAST) begin
            w_timeout_err_nxt = 1'b1;
            w_last_grant_nxt  = r_grant[1];
            w_grant_nxt       = 2'b00;
            w_state_nxt       = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_sel_valid) begin
      w_data_nxt      = w_sel ? i_req1_data : i_req0_data;
      w_last_flag_nxt = w_sel ? i_req1_last : i_req0_last;
      w_ack0_nxt      = ~w_sel;
      w_ack1_nxt      = w_sel;
      w_grant_nxt     = w_sel ? 2'b10 : 2'b01;
      w_data_rdy_nxt  = 1'b1;
      w_state_nxt     = ST_SEND;
    end
  end

  assign o_req0_ack    = r_ack0;
  assign o_req1_ack    = r_ack1;
  assign o_data_rdy    = r_data_rdy;
  assign o_data        = r_data;
  assign o_grant       = r_grant;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_timeout_err = r_timeout_err;

endmodule
